display_scan: RTL

Time-multiplexed scan controller for a common-anode multi-digit 7-segment display. It sits directly upstream of the per-digit hex segment decoder. It holds a multi-digit hexadecimal value and cycles through the digits, presenting one 4-bit nibble at a time on `digit` to the decoder while driving the matching active-low anode enable. A blanking gap precedes each digit slot to suppress ghosting, value updates take effect only at frame boundaries, and optional leading-zero blanking is provided.

---
 rtl/display_pkg.sv | 35 +++
 rtl/display_slot_timer.sv | 72 +++++++
 rtl/display_scan.sv | 123 ++++++++++++
 3 files changed

// File: rtl/display_pkg.sv
// Shared types, constants and helpers for the multiplexed 7-segment scan controller.
package display_pkg;

  // Phase within one digit slot: anodes dark first, then the selected digit lit.
  typedef enum logic {
    S_BLANK = 1'b0,
    S_ON    = 1'b1
  } scan_state_e;

  // Widest display the helpers below are sized for; DIGITS must not exceed it.
  localparam int MAX_DIGITS = 16;

  // Active-low anodes: every digit dark. Slice down to the actual digit count.
  localparam logic [MAX_DIGITS-1:0] ANODES_OFF = '1;

  // Bit i set when digit i is a leading zero: it and every more significant
  // digit up to digits-1 are zero. Digit 0 is never marked.
  function automatic logic [MAX_DIGITS-1:0] lead_zero_mask(
    input logic [4*MAX_DIGITS-1:0] val,
    input int                      digits
  );
    logic [MAX_DIGITS-1:0] m;
    logic                  all_zero;
    m        = '0;
    all_zero = 1'b1;
    for (int i = MAX_DIGITS - 1; i >= 1; i--) begin
      if (i < digits) begin
        all_zero = all_zero && (val[4*i +: 4] == 4'h0);
        m[i]     = all_zero;
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/display_slot_timer.sv
// Slot/digit timebase: counts cycles within a digit slot, steps the digit
// index at each slot end and tracks the blank/on phase of the current slot.
module display_slot_timer
  import display_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int DIV    = 50000,
  parameter int BLANK  = 1000,
  parameter int IDX_W  = $clog2(DIGITS)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  output logic             slot_end_o,   // last cycle of the current slot
  output logic             frame_wrap_o, // last cycle of the last digit's slot
  output logic             in_blank_o,   // current cycle is in the blank phase
  output logic             on_start_o,   // last blank cycle; next cycle lights
  output logic [IDX_W-1:0] idx_o
);

  localparam int CNT_W = $clog2(DIV);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  scan_state_e      st_q, st_d;
  logic             slot_end;
  logic             last_digit;
  logic             on_start;

  assign slot_end   = (cnt_q == CNT_W'(DIV - 1));
  assign last_digit = (idx_q == IDX_W'(DIGITS - 1));
  assign on_start   = (cnt_q == CNT_W'(BLANK - 1));

  // Counter next-state: wrap the slot counter and advance the digit index.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    idx_d = idx_q;
    if (slot_end) begin
      cnt_d = '0;
      idx_d = last_digit ? '0 : idx_q + IDX_W'(1);
    end
  end

  // Phase next-state: every slot opens dark and lights after BLANK cycles.
  always_comb begin
    st_d = st_q;
    if (slot_end) begin
      st_d = S_BLANK;
    end else if (on_start) begin
      st_d = S_ON;
    end
  end

  // Timebase registers; reset restarts at digit 0 in the blank phase.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      idx_q <= '0;
      st_q  <= S_BLANK;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      st_q  <= st_d;
    end
  end

  assign slot_end_o   = slot_end;
  assign frame_wrap_o = slot_end && last_digit;
  assign in_blank_o   = (st_q == S_BLANK);
  assign on_start_o   = on_start;
  assign idx_o        = idx_q;

endmodule

// File: rtl/display_scan.sv
// Time-multiplexed scan controller for a common-anode multi-digit 7-segment
// display. Value updates are deferred to frame boundaries; all outputs are
// registered and computed one cycle ahead from the timebase's next state.
module display_scan
  import display_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int DIV    = 50000,
  parameter int BLANK  = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  load,
  input  logic                  lzb,
  output logic [3:0]            digit,
  output logic [DIGITS-1:0]     anodes,
  output logic                  frame_tick
);

  localparam int IDX_W = $clog2(DIGITS);
  localparam int VAL_W = 4 * DIGITS;

  logic             slot_end;
  logic             frame_wrap;
  logic             in_blank;
  logic             on_start;
  logic [IDX_W-1:0] idx;

  display_slot_timer #(
    .DIGITS (DIGITS),
    .DIV    (DIV),
    .BLANK  (BLANK),
    .IDX_W  (IDX_W)
  ) u_timer (
    .clk_i        (clk),
    .rst_i        (rst),
    .slot_end_o   (slot_end),
    .frame_wrap_o (frame_wrap),
    .in_blank_o   (in_blank),
    .on_start_o   (on_start),
    .idx_o        (idx)
  );

  logic [VAL_W-1:0]        active_q, active_d;
  logic [VAL_W-1:0]        pending_q, pending_d;
  logic                    pend_v_q, pend_v_d;
  logic [3:0]              digit_q, digit_d;
  logic [DIGITS-1:0]       anodes_q, anodes_d;
  logic                    frame_tick_q, frame_tick_d;

  logic [IDX_W-1:0]        idx_nxt;
  logic                    on_next;
  logic [4*MAX_DIGITS-1:0] active_ext;
  logic [MAX_DIGITS-1:0]   lz_mask;

  // Value capture: a load on the wrap cycle goes straight to the display,
  // any other load is parked until the next wrap (last one wins).
  always_comb begin
    active_d  = active_q;
    pending_d = pending_q;
    pend_v_d  = pend_v_q;
    if (frame_wrap) begin
      if (load) begin
        active_d = value;
        pend_v_d = 1'b0;
      end else if (pend_v_q) begin
        active_d = pending_q;
        pend_v_d = 1'b0;
      end
    end else if (load) begin
      pending_d = value;
      pend_v_d  = 1'b1;
    end
  end

  // Output next-state: digit changes as a slot opens so the decoder settles
  // while dark; anodes light only in the on phase of a non-blanked digit.
  // active_q equals active_d whenever the next cycle is in the on phase.
  always_comb begin
    idx_nxt    = frame_wrap ? '0 : idx + IDX_W'(1);
    on_next    = !slot_end && (!in_blank || on_start);
    active_ext = '0;
    active_ext[VAL_W-1:0] = active_q;
    lz_mask    = lead_zero_mask(active_ext, DIGITS);

    digit_d = digit_q;
    if (slot_end) begin
      digit_d = active_d[4*idx_nxt +: 4];
    end

    anodes_d = ANODES_OFF[DIGITS-1:0];
    if (on_next && !(lzb && lz_mask[idx])) begin
      anodes_d[idx] = 1'b0;
    end

    frame_tick_d = frame_wrap;
  end

  // Value and output registers; reset drops any parked value.
  always_ff @(posedge clk) begin
    if (rst) begin
      active_q     <= '0;
      pending_q    <= '0;
      pend_v_q     <= 1'b0;
      digit_q      <= 4'h0;
      anodes_q     <= ANODES_OFF[DIGITS-1:0];
      frame_tick_q <= 1'b0;
    end else begin
      active_q     <= active_d;
      pending_q    <= pending_d;
      pend_v_q     <= pend_v_d;
      digit_q      <= digit_d;
      anodes_q     <= anodes_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign digit      = digit_q;
  assign anodes     = anodes_q;
  assign frame_tick = frame_tick_q;

endmodule
